// File: rtl/sin_phase_gen.sv
// NCO phase front end for the quadratic-interpolation sine generator.
// 47-bit phase accumulator with phase offset, fixed FTW mode and linear FTW sweep.
module sin_phase_gen #(
  parameter int PHASE_BITS = 47,
  parameter int DWELL_BITS = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  run_i,
  input  logic [PHASE_BITS-1:0] ftw_i,
  input  logic [PHASE_BITS-1:0] ofs_i,
  input  logic                  ftw_ld_i,
  input  logic                  sweep_start_i,
  input  logic [PHASE_BITS-1:0] sweep_stop_ftw_i,
  input  logic [PHASE_BITS-1:0] sweep_step_i,
  input  logic [DWELL_BITS-1:0] dwell_i,
  input  logic                  phase_clr_i,
  output logic                  valid_o,
  output logic [PHASE_BITS-1:0] phase_o,
  output logic                  sweep_busy_o,
  output logic                  sweep_done_o
);

  typedef enum logic {
    ST_FIXED = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PHASE_BITS-1:0] r_acc;
  logic [PHASE_BITS-1:0] r_ftw_cur;
  logic [PHASE_BITS-1:0] r_ofs;
  logic [PHASE_BITS-1:0] r_stop;
  logic [PHASE_BITS-1:0] r_step;
  logic [PHASE_BITS-1:0] r_phase;
  logic [PHASE_BITS-1:0] w_ftw_nxt;
  logic [DWELL_BITS-1:0] r_dwell_m1;
  logic [DWELL_BITS-1:0] r_dwell_cnt;
  logic [DWELL_BITS-1:0] w_cnt_nxt;
  logic [PHASE_BITS:0]   w_step_sum;
  logic                  r_valid;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_emit;
  logic                  w_dwell_end;
  logic                  w_reach_stop;
  logic                  w_start_degen;

  // The stop test is done one bit wider so a sum past 2^47 still counts as reaching stop.
  assign w_emit        = run_i & ~phase_clr_i;
  assign w_step_sum    = {1'b0, r_ftw_cur} + {1'b0, r_step};
  assign w_reach_stop  = (w_step_sum >= {1'b0, r_stop});
  assign w_dwell_end   = (r_dwell_cnt == r_dwell_m1);
  assign w_start_degen = (sweep_step_i == '0) || (sweep_stop_ftw_i <= ftw_i);

  always_comb begin
    w_state_nxt = r_state;
    w_ftw_nxt   = r_ftw_cur;
    w_cnt_nxt   = r_dwell_cnt;
    w_done_nxt  = 1'b0;
    if (ftw_ld_i) begin
      w_ftw_nxt   = ftw_i;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_FIXED;
    end else if (sweep_start_i) begin
      w_ftw_nxt = ftw_i;
      w_cnt_nxt = '0;
      if (w_start_degen) begin
        w_state_nxt = ST_FIXED;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_SWEEP;
      end
    end else if ((r_state == ST_SWEEP) && w_emit) begin
      if (w_dwell_end) begin
        w_cnt_nxt = '0;
        if (w_reach_stop) begin
          w_ftw_nxt   = r_stop;
          w_state_nxt = ST_FIXED;
          w_done_nxt  = 1'b1;
        end else begin
          w_ftw_nxt = w_step_sum[PHASE_BITS-1:0];
        end
      end else begin
        w_cnt_nxt = r_dwell_cnt + DWELL_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_FIXED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dwell is stored minus one so a programmed 0 behaves exactly like 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc       <= '0;
      r_ftw_cur   <= '0;
      r_ofs       <= '0;
      r_stop      <= '0;
      r_step      <= '0;
      r_dwell_m1  <= '0;
      r_dwell_cnt <= '0;
      r_phase     <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ftw_cur   <= w_ftw_nxt;
      r_dwell_cnt <= w_cnt_nxt;
      r_done      <= w_done_nxt;
      r_valid     <= w_emit;
      if (w_emit) begin
        r_phase <= r_acc + r_ofs;
      end
      if (phase_clr_i) begin
        r_acc <= '0;
      end else if (run_i) begin
        r_acc <= r_acc + r_ftw_cur;
      end
      if (ftw_ld_i) begin
        r_ofs <= ofs_i;
      end else if (sweep_start_i) begin
        r_ofs      <= ofs_i;
        r_stop     <= sweep_stop_ftw_i;
        r_step     <= sweep_step_i;
        r_dwell_m1 <= (dwell_i == '0) ? '0 : (dwell_i - DWELL_BITS'(1));
      end
    end
  end

  assign valid_o      = r_valid;
  assign phase_o      = r_phase;
  assign sweep_busy_o = (r_state == ST_SWEEP);
  assign sweep_done_o = r_done;

endmodule

// File: tb/tb_sin_phase_gen.sv
// Self-checking bench for sin_phase_gen: directed scenarios with literal expectations
// plus randomized control traffic, all compared against a sample-index based model.
module tb_sin_phase_gen;

  localparam int PB = 47;
  localparam int DB = 16;

  logic          clk;
  logic          resetn;
  logic          run_i;
  logic [PB-1:0] ftw_i;
  logic [PB-1:0] ofs_i;
  logic          ftw_ld_i;
  logic          sweep_start_i;
  logic [PB-1:0] sweep_stop_ftw_i;
  logic [PB-1:0] sweep_step_i;
  logic [DB-1:0] dwell_i;
  logic          phase_clr_i;
  logic          valid_o;
  logic [PB-1:0] phase_o;
  logic          sweep_busy_o;
  logic          sweep_done_o;

  int checks = 0;
  int errors = 0;

  // Model state: sweep frequency is derived from the sample index, not from a stepped register.
  logic [PB-1:0] mAcc = '0, mOfs = '0, mFtw = '0, mStart = '0, mStep = '0, mStop = '0;
  bit            mSweep = 1'b0;
  int            mN = 0;
  int            mDwell = 1;
  logic          eValid = 1'b0, eBusy = 1'b0, eDone = 1'b0;
  logic [PB-1:0] ePhase = '0;

  logic [3:0]    litMask = 4'h0;
  logic          litValid = 1'b0, litBusy = 1'b0, litDone = 1'b0;
  logic [PB-1:0] litPhase = '0;

  sin_phase_gen #(.PHASE_BITS(PB), .DWELL_BITS(DB)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .run_i            (run_i),
    .ftw_i            (ftw_i),
    .ofs_i            (ofs_i),
    .ftw_ld_i         (ftw_ld_i),
    .sweep_start_i    (sweep_start_i),
    .sweep_stop_ftw_i (sweep_stop_ftw_i),
    .sweep_step_i     (sweep_step_i),
    .dwell_i          (dwell_i),
    .phase_clr_i      (phase_clr_i),
    .valid_o          (valid_o),
    .phase_o          (phase_o),
    .sweep_busy_o     (sweep_busy_o),
    .sweep_done_o     (sweep_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint unsigned sweepFtw(input int n);
    return longint'(mStart) + longint'(mStep) * longint'(n / mDwell);
  endfunction

  function automatic logic [PB-1:0] curFtw();
    longint unsigned v;
    if (mSweep) begin
      v = sweepFtw(mN);
      return v[PB-1:0];
    end
    return mFtw;
  endfunction

  // Reference model, evaluated on the inputs present at each active edge.
  always @(posedge clk or negedge resetn) begin
    logic          emit;
    logic [PB-1:0] used;
    if (!resetn) begin
      mAcc = '0; mOfs = '0; mFtw = '0; mSweep = 1'b0; mN = 0;
      eValid = 1'b0; ePhase = '0; eBusy = 1'b0; eDone = 1'b0;
    end else begin
      emit  = run_i && !phase_clr_i;
      used  = curFtw();
      eDone = 1'b0;
      if (emit) ePhase = mAcc + mOfs;
      eValid = emit;
      if (phase_clr_i) mAcc = '0;
      else if (run_i) mAcc = mAcc + used;
      if (ftw_ld_i) begin
        mSweep = 1'b0; mFtw = ftw_i; mOfs = ofs_i;
      end else if (sweep_start_i) begin
        mOfs = ofs_i; mStart = ftw_i; mStep = sweep_step_i; mStop = sweep_stop_ftw_i;
        mDwell = (dwell_i == '0) ? 1 : int'(dwell_i);
        mN = 0;
        if (sweep_step_i == '0 || sweep_stop_ftw_i <= ftw_i) begin
          mSweep = 1'b0; mFtw = ftw_i; eDone = 1'b1;
        end else begin
          mSweep = 1'b1;
        end
      end else if (mSweep && emit) begin
        mN++;
        if ((mN % mDwell == 0) && (sweepFtw(mN) >= longint'(mStop))) begin
          mSweep = 1'b0; mFtw = mStop; eDone = 1'b1;
        end
      end
      eBusy = mSweep;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: model every cycle, plus any pinned literal expectation.
  always @(negedge clk) begin
    checkOutput("valid_o", 64'(valid_o), 64'(eValid));
    checkOutput("phase_o", 64'(phase_o), 64'(ePhase));
    checkOutput("sweep_busy_o", 64'(sweep_busy_o), 64'(eBusy));
    checkOutput("sweep_done_o", 64'(sweep_done_o), 64'(eDone));
    if (litMask[0]) checkOutput("lit_valid", 64'(valid_o), 64'(litValid));
    if (litMask[1]) checkOutput("lit_phase", 64'(phase_o), 64'(litPhase));
    if (litMask[2]) checkOutput("lit_busy", 64'(sweep_busy_o), 64'(litBusy));
    if (litMask[3]) checkOutput("lit_done", 64'(sweep_done_o), 64'(litDone));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    litMask = 4'h0;
  endtask

  task automatic expectLit(input logic [3:0] mask, input logic v, input logic [PB-1:0] ph,
                           input logic b, input logic d);
    litMask = mask; litValid = v; litPhase = ph; litBusy = b; litDone = d;
  endtask

  task automatic applyStimulus(input logic run, input logic ld, input logic start, input logic clr);
    run_i = run; ftw_ld_i = ld; sweep_start_i = start; phase_clr_i = clr;
  endtask

  initial begin
    logic [PB-1:0] swPh [11];
    logic [PB-1:0] wrapPh [4];
    logic [63:0]   rnd;
    int            r;
    swPh   = '{47'd0, 47'd100, 47'd200, 47'd300, 47'd450, 47'd600, 47'd750,
               47'd950, 47'd1150, 47'd1350, 47'd1570};
    wrapPh = '{47'd0, (47'd1 << 46) + 47'd1, 47'd2, (47'd1 << 46) + 47'd3};
    resetn = 1'b0;
    ftw_i = '0; ofs_i = '0; sweep_stop_ftw_i = '0; sweep_step_i = '0; dwell_i = '0;
    applyStimulus(0, 0, 0, 0);
    tick();
    expectLit(4'hF, 0, '0, 0, 0);
    tick();
    resetn = 1'b1;

    // Fixed FTW 2^37: valid rises one cycle after run, phase steps by 2^37.
    ftw_i = 47'd1 << 37; ofs_i = '0;
    applyStimulus(0, 1, 0, 0);
    tick();
    expectLit(4'hD, 0, '0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    tick();
    expectLit(4'h3, 1, '0, 0, 0);
    for (int i = 1; i < 5; i++) begin
      tick();
      expectLit(4'h3, 1, 47'(i) << 37, 0, 0);
    end

    // Wrap modulo 2^47.
    ftw_i = (47'd1 << 46) + 47'd1;
    applyStimulus(0, 1, 0, 1);
    tick();
    expectLit(4'h1, 0, '0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expectLit(4'h3, 1, wrapPh[i], 0, 0);
    end

    // Constant phase from offset, then clear with run held high.
    ftw_i = '0; ofs_i = 47'd1 << 45;
    applyStimulus(0, 1, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expectLit(4'h3, 1, 47'd1 << 45, 0, 0);
    end
    applyStimulus(1, 0, 0, 1);
    tick();
    expectLit(4'h3, 0, 47'd1 << 45, 0, 0);
    applyStimulus(1, 0, 0, 0);
    tick();
    expectLit(4'h3, 1, 47'd1 << 45, 0, 0);

    // Sweep 100 -> 220 step 50 dwell 3.
    ftw_i = 47'd100; ofs_i = '0; sweep_stop_ftw_i = 47'd220; sweep_step_i = 47'd50; dwell_i = 16'd3;
    applyStimulus(0, 0, 1, 1);
    tick();
    expectLit(4'hD, 0, '0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      tick();
      expectLit(4'hF, 1, swPh[i], (i < 8), (i == 8));
    end

    // Same sweep with run toggling every cycle.
    applyStimulus(0, 0, 1, 1);
    tick();
    for (int i = 0; i < 24; i++) begin
      applyStimulus((i % 2) == 0, 0, 0, 0);
      tick();
      if ((i % 2) != 0) expectLit(4'h1, 0, '0, 0, 0);
    end

    // Mid-sweep abort by ftw_ld, then a degenerate sweep start.
    applyStimulus(0, 0, 1, 1);
    tick();
    applyStimulus(1, 0, 0, 0);
    repeat (4) tick();
    ftw_i = 47'd7;
    applyStimulus(1, 1, 0, 0);
    tick();
    expectLit(4'hC, 0, '0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    tick();
    expectLit(4'hC, 0, '0, 0, 0);
    ftw_i = 47'd500; sweep_stop_ftw_i = 47'd300; sweep_step_i = 47'd10;
    applyStimulus(1, 0, 1, 0);
    tick();
    expectLit(4'hC, 0, '0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    tick();
    expectLit(4'hC, 0, '0, 0, 0);
    repeat (3) tick();

    // Randomized control traffic.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      rnd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ftw_i = rnd[PB-1:0];
      else ftw_i = 47'($urandom_range(0, 1000));
      rnd = {$urandom, $urandom};
      ofs_i = rnd[PB-1:0];
      sweep_stop_ftw_i = ftw_i + 47'($urandom_range(0, 2000)) - 47'd200;
      sweep_step_i = 47'($urandom_range(0, 300));
      dwell_i = 16'($urandom_range(0, 4));
      if (r == 99) applyStimulus(1, 1, 1, 1);
      else applyStimulus($urandom_range(0, 3) != 0, (r >= 3 && r < 6), (r >= 6 && r < 10), (r < 3));
      tick();
    end
    applyStimulus(0, 0, 0, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sin_phase_gen.md
Name: sin_phase_gen

Overview:
- Phase-generating front end (NCO) that drives the 47-bit phase / valid input of the quadratic-interpolation sine generator. It is the producing end of that phase interface.
- A 47-bit accumulator advances by a frequency tuning word (FTW) on every emitted sample; a programmable phase offset is added on output.
- An optional linear FTW sweep steps the frequency from a start FTW to a stop FTW, holding each FTW for a programmable number of emitted samples.

Parameters:
- PHASE_BITS, 47, accumulator/phase width; phase[46:45] is the quadrant, matching the sine block.
- DWELL_BITS, 16, width of the dwell counter and of dwell_i.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- run_i  in  1  level; 1 = emit one sample per cycle, 0 = pause (state held)
- ftw_i  in  PHASE_BITS  FTW for fixed mode; start FTW for sweeps
- ofs_i  in  PHASE_BITS  phase offset, captured on ftw_ld_i or sweep_start_i
- ftw_ld_i  in  1  pulse: load ftw_i/ofs_i, enter FIXED mode
- sweep_start_i  in  1  pulse: load ftw_i/ofs_i as start, enter SWEEP mode
- sweep_stop_ftw_i  in  PHASE_BITS  sweep end FTW, captured on sweep_start_i
- sweep_step_i  in  PHASE_BITS  FTW increment per dwell, captured on sweep_start_i
- dwell_i  in  DWELL_BITS  samples per FTW step, captured on sweep_start_i; 0 is treated as 1
- phase_clr_i  in  1  pulse: zero the accumulator
- valid_o  out  1  phase_o valid (drives the sine block valid_i)
- phase_o  out  PHASE_BITS  registered phase (drives the sine block phase)
- sweep_busy_o  out  1  high while in SWEEP state
- sweep_done_o  out  1  one-cycle pulse when a sweep reaches its stop FTW

Behaviour:
- Reset (asynchronous, active-low): acc=0, ftw_cur=0, ofs_r=0, dwell_cnt=0, state=FIXED, valid_o=0, phase_o=0, sweep_busy_o=0, sweep_done_o=0.
- Emission, on a cycle with run_i=1 and no phase_clr_i:
  - phase_o <= acc + ofs_r (mod 2^47), valid_o <= 1.
  - acc <= acc + ftw_cur (mod 2^47, natural wrap, no saturation).
  - Latency is one clock from the run_i edge to valid_o.
  - After a clear, the first emitted phase equals ofs_r.
- run_i=0: valid_o <= 0; phase_o holds its last value; acc, ftw_cur, dwell_cnt and state hold.
- Priority when several controls occur in one cycle: phase_clr_i > ftw_ld_i > sweep_start_i > sweep stepping.
- phase_clr_i:
  - acc <= 0 and valid_o <= 0 that cycle.
  - ftw_cur, state and dwell_cnt are unaffected.
  - Any ftw_ld_i/sweep_start_i in the same cycle is also applied.
- ftw_ld_i:
  - ftw_cur <= ftw_i, ofs_r <= ofs_i, state <= FIXED, dwell_cnt <= 0.
  - acc is not reset, so the phase stays continuous.
  - The new FTW is first used by the emission in the following cycle.
  - Asserting it in SWEEP aborts the sweep: sweep_busy_o falls and no sweep_done_o pulse is produced.
- sweep_start_i:
  - Captures ftw_i, ofs_i, stop, step and dwell; ftw_cur <= ftw_i; dwell_cnt <= 0; state <= SWEEP.
  - Asserting it while already sweeping restarts the sweep.
  - Degenerate case: if step==0 or stop<=start, the block enters FIXED at the start FTW and sweep_done_o pulses on the next cycle.
- SWEEP stepping:
  - dwell_cnt increments once per emitted sample.
  - When dwell_cnt reaches dwell-1 on an emitted sample:
    - dwell_cnt <= 0.
    - If ftw_cur+step >= stop (computed 48-bit unsigned, no wrap): ftw_cur <= stop, state <= FIXED, sweep_done_o pulses for 1 cycle.
    - Otherwise ftw_cur <= ftw_cur+step.
  - A paused run_i freezes stepping.
- sweep_busy_o = (state==SWEEP), registered.
- Downstream: the sine block adds its own fixed latency. This block has no backpressure and must emit at most one sample per clock.

Test Plan:
- Reset, then ftw_ld_i with ftw=2^37, ofs=0, run_i=1 from the next cycle -> phase_o sequence 0, 2^37, 2*2^37, ...; valid_o rises 1 cycle after run_i.
- ftw=2^46+1, run for 4 samples -> phase wraps mod 2^47: 0, 2^46+1, 2, 2^46+3.
- ofs=2^45, ftw=0 -> constant phase_o=2^45 (quadrant 1). Then phase_clr_i with run_i=1 -> valid_o=0 for one cycle, then phase_o=2^45 again.
- Sweep start=100, step=50, stop=220, dwell=3, run_i=1:
  - FTW sequence 100 x3, 150 x3, 200 x3, then 220 held.
  - sweep_done_o pulses once, on the cycle of the third sample at 200.
  - sweep_busy_o falls on that same transition.
- Sweep with run_i toggled 0/1 every cycle -> identical FTW/phase sample sequence to the continuous case; valid_o low on paused cycles.
- Mid-sweep ftw_ld_i with ftw=7 -> FIXED immediately, no sweep_done_o. Also: sweep_start_i with stop<=start -> sweep_done_o one cycle later, ftw_cur=start.
